// File: rtl/fitness_scorer.sv
// Scoring stage for evolved 4-output logic individuals: compares candidate truth-table
// words against expected words under a row mask and accumulates a saturating fitness score.
module fitness_scorer #(
  parameter int WIDTH   = 16,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [WIDTH-1:0]   in_mask,
  input  logic [WIDTH-1:0]   y3,
  input  logic [WIDTH-1:0]   y2,
  input  logic [WIDTH-1:0]   y1,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   e3,
  input  logic [WIDTH-1:0]   e2,
  input  logic [WIDTH-1:0]   e1,
  input  logic [WIDTH-1:0]   e0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] total,
  output logic               perfect,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // valid never depends on ready, and accepted data is latched so inputs may change afterwards.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [1:0]              idx;
  logic [3:0][WIDTH-1:0]   y_q, e_q;
  logic [WIDTH-1:0]        mask_q;
  logic                    last_q;
  logic                    accept, release_res;
  logic [WIDTH-1:0]        diff, match;
  logic [CW-1:0]           match_cnt, mask_cnt;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Accumulators clamp at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [CW-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  assign accept      = (state == IDLE) && in_valid && in_ready;
  assign release_res = (state == RESULT) && out_valid && out_ready;
  assign diff        = (y_q[idx] ^ e_q[idx]) & mask_q;
  assign match       = ~(y_q[idx] ^ e_q[idx]) & mask_q;
  assign match_cnt   = popcount(match);
  assign mask_cnt    = popcount(mask_q);
  assign state_dbg   = state;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = COUNT;
      COUNT:   if (idx == 2'd3) state_next = last_q ? RESULT : IDLE;
      RESULT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      idx       <= 2'd0;
      y_q       <= '0;
      e_q       <= '0;
      mask_q    <= '0;
      last_q    <= 1'b0;
      score     <= '0;
      total     <= '0;
      perfect   <= 1'b1;
    end else begin
      state     <= state_next;
      // Registered flags so in_ready stays low until the first clock after reset release.
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == RESULT);
      if (accept) begin
        y_q    <= {y3, y2, y1, y0};
        e_q    <= {e3, e2, e1, e0};
        mask_q <= in_mask;
        last_q <= in_last;
        idx    <= 2'd0;
      end else if (state == COUNT) begin
        idx   <= idx + 2'd1;
        score <= sat_add(score, match_cnt);
        total <= sat_add(total, mask_cnt);
        if (|diff) perfect <= 1'b0;
      end else if (release_res) begin
        score   <= '0;
        total   <= '0;
        perfect <= 1'b1;
      end
    end
  end

endmodule
